// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Combinational only: no latency, no flow control.
// Holds the fill-counter width function and the legal pattern-length bounds.
package seq_det_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    // Width of a counter that must reach pat_w inclusive.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Generic saturating match counter; clr wins over a simultaneous inc.
// Latency: count visible the cycle after the inc edge.
// Backpressure: none; increments are dropped once saturated at all-ones.
module seq_det_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime pattern, overlap select and match counter (SEQ_DET_CNT_EN).
// Latency: Y pulses for one cycle after the edge sampling the final pattern bit.
// Backpressure: none; en=0 cycles are gaps that hold history.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             X,
    input  logic             en,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             Y,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = fill_w(PAT_W);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W out of legal range");
    end

    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] nxt;
    logic [FW-1:0]    fill;
    logic             hit;

    assign nxt = {hist[PAT_W-2:0], X};
    // fill counts bits since restart, so stale history never completes a match.
    assign hit = en && !pat_load && (fill >= FW'(PAT_W - 1)) && (nxt == pat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat  <= PATTERN;
            hist <= '0;
            fill <= '0;
            Y    <= 1'b0;
        end else if (pat_load) begin
            pat  <= pat_in;
            hist <= '0;
            fill <= '0;
            Y    <= 1'b0;
        end else if (en) begin
            hist <= nxt;
            Y    <= hit;
            if (hit && !overlap) begin
                fill <= '0;
            end else if (fill != FW'(PAT_W)) begin
                fill <= fill + 1'b1;
            end
        end else begin
            Y <= 1'b0;
        end
    end

`ifdef SEQ_DET_CNT_EN
    seq_det_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (hit),
        .cnt (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed test-plan scenarios plus randomized traffic
// against a queue-based model of "bits received since last restart".
module tb_seq_detector_param;

    localparam int PW = 3;

`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          X = 1'b0;
    logic          en = 1'b0;
    logic          overlap = 1'b0;
    logic          pat_load = 1'b0;
    logic [PW-1:0] pat_in = '0;
    logic          cnt_clr = 1'b0;
    logic          Y, Y2;
    logic [7:0]    match_cnt;
    logic [1:0]    match_cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [PW-1:0] m_pat = 3'b101;
    bit            m_q[$];
    logic          m_y = 1'b0;
    logic [7:0]    m_cnt = '0;
    logic [1:0]    m_cnt2 = '0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(PW), .PATTERN(3'b101), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .X(X), .en(en), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .Y(Y), .match_cnt(match_cnt)
    );

    seq_detector_param #(.PAT_W(PW), .PATTERN(3'b101), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .X(X), .en(en), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .Y(Y2), .match_cnt(match_cnt2)
    );

    function automatic logic [7:0] exp_cnt();
        return CNT_ON ? m_cnt : 8'd0;
    endfunction

    function automatic logic [1:0] exp_cnt2();
        return CNT_ON ? m_cnt2 : 2'd0;
    endfunction

    // Drive one edge's inputs, advance the model, and stop 1 time unit after the edge.
    task automatic step(input logic x_i, input logic e_i, input logic ov_i,
                        input logic ld_i, input logic [PW-1:0] pin_i, input logic clr_i);
        bit hit;
        X = x_i; en = e_i; overlap = ov_i; pat_load = ld_i; pat_in = pin_i; cnt_clr = clr_i;
        hit = 1'b0;
        if (ld_i) begin
            m_pat = pin_i;
            m_q.delete();
        end else if (e_i) begin
            m_q.push_back(x_i);
            if (m_q.size() >= PW) begin
                hit = 1'b1;
                for (int k = 0; k < PW; k++)
                    if (m_q[m_q.size() - PW + k] != m_pat[PW-1-k]) hit = 1'b0;
            end
            if (hit && !ov_i) m_q.delete();
            else if (m_q.size() > PW) void'(m_q.pop_front());
        end
        m_y = hit;
        if (clr_i) begin
            m_cnt = '0; m_cnt2 = '0;
        end else if (hit) begin
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pat = 3'b101; m_q.delete(); m_y = 1'b0; m_cnt = '0; m_cnt2 = '0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (Y !== 1'b0) begin errors++; $display("FAIL reset_y got %b want 0", Y); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
        checks++; if (match_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got %0d want 0", match_cnt2); end
        rst = 1'b1;
    endtask

    task automatic test_stream(input string name, input logic ov, input logic [4:0] exp_y, input int hits);
        logic [4:0] bits;
        bits = 5'b10101;
        step(0, 0, ov, 1, 3'b101, 1);
        for (int i = 0; i < 5; i++) begin
            step(bits[4-i], 1, ov, 0, 3'b101, 0);
            checks++;
            if (Y !== exp_y[4-i] || Y !== m_y) begin
                errors++; $display("FAIL %s_y bit%0d got %b want %b", name, i + 1, Y, exp_y[4-i]);
            end
        end
        step(0, 0, ov, 0, 3'b101, 0);
        checks++;
        if (match_cnt !== (CNT_ON ? 8'(hits) : 8'd0) || match_cnt !== exp_cnt()) begin
            errors++; $display("FAIL %s_cnt got %0d want %0d", name, match_cnt, CNT_ON ? hits : 0);
        end
    endtask

    task automatic test_gaps();
        logic [4:0] xs, es, ey;
        xs = 5'b10001; es = 5'b10101; ey = 5'b00001;
        step(0, 0, 0, 1, 3'b101, 1);
        for (int i = 0; i < 5; i++) begin
            step(xs[4-i], es[4-i], 0, 0, 3'b101, 0);
            checks++;
            if (Y !== ey[4-i]) begin errors++; $display("FAIL gaps_y step%0d got %b want %b", i, Y, ey[4-i]); end
        end
    endtask

    task automatic test_pat_load();
        logic [2:0] xs, ey;
        xs = 3'b110; ey = 3'b001;
        step(0, 0, 1, 1, 3'b101, 1);
        step(1, 1, 1, 0, 3'b101, 0);
        step(1, 1, 1, 0, 3'b101, 0);
        step(1, 1, 1, 1, 3'b110, 0);
        checks++; if (Y !== 1'b0) begin errors++; $display("FAIL load_edge_y got %b want 0", Y); end
        for (int i = 0; i < 3; i++) begin
            step(xs[2-i], 1, 1, 0, 3'b110, 0);
            checks++;
            if (Y !== ey[2-i]) begin errors++; $display("FAIL load_y bit%0d got %b want %b", i + 1, Y, ey[2-i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] xs, ey;
        xs = 3'b101; ey = 3'b001;
        step(0, 0, 0, 1, 3'b110, 0);
        step(1, 1, 0, 0, 3'b110, 0);
        step(0, 1, 0, 0, 3'b110, 0);
        rst = 1'b0;
        #2;
        model_reset();
        checks++; if (Y !== 1'b0 || match_cnt !== 8'd0) begin
            errors++; $display("FAIL midrst_async got Y=%b cnt=%0d want 0/0", Y, match_cnt);
        end
        X = 1; en = 1; pat_load = 0; cnt_clr = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(xs[2-i], 1, 0, 0, 3'b000, 0);
            checks++;
            if (Y !== ey[2-i]) begin errors++; $display("FAIL midrst_y bit%0d got %b want %b", i + 1, Y, ey[2-i]); end
        end
    endtask

    task automatic test_saturate();
        step(0, 0, 1, 1, 3'b101, 1);
        for (int i = 0; i < 9; i++) step(((i % 2) == 0), 1, 1, 0, 3'b101, 0);
        checks++;
        if (match_cnt2 !== (CNT_ON ? 2'd3 : 2'd0)) begin
            errors++; $display("FAIL sat_cnt2 got %0d want %0d", match_cnt2, CNT_ON ? 3 : 0);
        end
        checks++;
        if (match_cnt !== (CNT_ON ? 8'd4 : 8'd0)) begin
            errors++; $display("FAIL sat_cnt got %0d want %0d", match_cnt, CNT_ON ? 4 : 0);
        end
        step(0, 1, 1, 0, 3'b101, 0);
        step(1, 1, 1, 0, 3'b101, 1);
        checks++;
        if (Y !== 1'b1 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
            errors++; $display("FAIL clr_hit got Y=%b cnt=%0d cnt2=%0d want 1/0/0", Y, match_cnt, match_cnt2);
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] p;
        for (int i = 0; i < 1500; i++) begin
            p = PW'($urandom_range(0, 7));
            step($urandom_range(0, 1), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 39) == 0), p, ($urandom_range(0, 49) == 0));
            checks++;
            if (Y !== m_y || Y2 !== m_y) begin
                errors++; $display("FAIL rand_y i=%0d got %b/%b want %b", i, Y, Y2, m_y);
            end
            checks++;
            if (match_cnt !== exp_cnt() || match_cnt2 !== exp_cnt2()) begin
                errors++; $display("FAIL rand_cnt i=%0d got %0d/%0d want %0d/%0d",
                                   i, match_cnt, match_cnt2, exp_cnt(), exp_cnt2());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream("nonovl", 1'b0, 5'b00100, 1);
        test_stream("ovl", 1'b1, 5'b00101, 2);
        test_gaps();
        test_pat_load();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
